dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller directly downstream of the load/store unit. It consumes the LSU's fire-and-forget memory read and write strobes and serialises them onto a single-port word memory. Reads are buffered in a small request FIFO and answered in order with a fixed-latency `mem_rd_resp`/`mem_rd_data` pulse. Writes are never stalled and take priority over reads.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width
- `DATA_W`, 32: word width
- `DEPTH_WORDS`, 1024: memory depth in words; power of two
- `RQ_DEPTH`, 4: read-request FIFO entries; power of two, ≥2
- `RD_LAT`, 2: cycles from service to response; ≥1

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `rst` in 1: synchronous, active-low reset
- `rd_valid` in 1: read request this cycle; there is no ready signal, so the request must be accepted or flagged
- `rd_addr` in ADDR_W: read byte address
- `rd_resp` out 1: one-cycle pulse; read data valid
- `rd_data` out DATA_W: read data, valid only while `rd_resp` is high
- `wr_valid` in 1: write this cycle; always accepted
- `wr_addr` in ADDR_W: write byte address
- `wr_data` in DATA_W: write data
- `rq_count` out $clog2(RQ_DEPTH)+1: current FIFO occupancy
- `overflow` out 1: sticky; a read was dropped

## Operation
- Word index is `addr[2 +: $clog2(DEPTH_WORDS)]`.
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo the memory size.
- The memory array has no reset; contents are X until written.
- Each cycle, the port arbiter picks one action, in priority order:
  1. `wr_valid` high: perform the write.
  2. Otherwise, FIFO non-empty: pop the head and perform the read (the "service" cycle).
  3. Otherwise: idle.
- Enqueue: `rd_valid` pushes `rd_addr` into the FIFO.
  - It is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the request is dropped, and `overflow` is set at the next edge and held until reset.
- Responses come out strictly in request order; there are no tags.
- A serviced read observes every write performed in earlier cycles.
  - A write in the same cycle as an enqueue is visible to that read, because service always happens later.
- Writes and reads are never reordered with respect to the port: the write in cycle N lands at the edge ending cycle N.
- The response pipeline is RD_LAT stages of valid+data shift registers. The array read occurs at the end of the service cycle; further stages are plain flops.
- Reset values: `rd_resp`=0, `rd_data`=0, `rq_count`=0, `overflow`=0. FIFO pointers and all pipeline valids are cleared.

## Timing
- Minimum latency: `rd_valid` in cycle T, with FIFO empty and no write at T+1.
  - Service occurs in T+1.
  - `rd_resp` is high in cycle T+1+RD_LAT (T+3 at the default).
- Each cycle with `wr_valid` asserted while the FIFO is non-empty delays all pending responses by one cycle.
- Sustained throughput is one read per cycle when there are no writes. Back-to-back requests produce back-to-back responses.
- `rq_count` updates at the edge: +1 on an accepted push, −1 on a pop, unchanged on a simultaneous push and pop.
- Wrap-around: FIFO pointers use $clog2(RQ_DEPTH)+1 bits. Full means the MSBs differ and the low bits are equal.
- Reset asserted mid-operation: queued and in-flight reads are discarded, and no `rd_resp` fires in the cycle after the reset edge. Memory contents are preserved.
- Responses have no backpressure; `rd_resp` is never held for more than one cycle.

## Structure
- Add `DMEM_DEPTH_WORDS`, `DMEM_RQ_DEPTH` and `DMEM_RD_LAT` defaults to the shared core package, next to `ROB_IDX_W` and `PHYS_REG_IDX_W`.
- Sub-module `rd_req_fifo`: a generic synchronous FIFO with parameters `WIDTH` and `DEPTH`.
  - Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`.
  - Its reset is the same active-low synchronous `rst`.
- The top level holds the arbiter, the memory array and the RD_LAT response pipeline.

## Test plan
- Write 0xDEADBEEF @0x40 at T0; read 0x40 at T1 → `rd_resp` at T4 with data 0xDEADBEEF; `rq_count` is 1 for exactly one cycle.
- Read 0x40, 0x44 and 0x48 in three consecutive cycles, after preloading 1, 2, 3 → three consecutive `rd_resp` pulses carrying 1, 2, 3.
- Queue a read of 0x10 (preloaded 5) while `wr_valid` is held for 3 cycles writing 7 to 0x10 → response delayed 3 cycles, data 7.
- RQ_DEPTH=4 with writes held high and 5 reads pushed → `rq_count`=4 and `overflow`=1; after writes stop, exactly 4 responses arrive in order.
- Address aliasing: write 9 @0x0, then read @(DEPTH_WORDS*4) → data 9; read @0x3 → data 9.
- Assert `rst` low for one cycle with 3 reads queued and 1 in flight → no `rd_resp` afterwards, `rq_count`=0, `overflow`=0, and a previously written word still reads back correctly.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared core package: index widths and data-memory controller defaults.
// No ports; imported by the pipeline and memory-side modules.
package dmem_ctrl_pkg;

    localparam int ROB_IDX_W        = 6;
    localparam int PHYS_REG_IDX_W   = 7;
    localparam int DMEM_DEPTH_WORDS = 1024;
    localparam int DMEM_RQ_DEPTH    = 4;
    localparam int DMEM_RD_LAT      = 2;

    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_WRITE,
        PORT_READ
    } port_op_e;

endpackage

// File: rtl/rd_req_fifo.sv
// Generic synchronous FIFO with occupancy count; pointers carry a wrap bit.
// Ports: clk, rst (sync active-low), push/din, pop/dout, full, empty, count.
module rd_req_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign count = wptr - rptr;
    assign dout  = store[rptr[PTR_W-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && rst) store[wptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: write-priority single-port arbiter, read FIFO,
// word array and RD_LAT response pipe. Ports: clk, rst (sync active-low),
// rd_valid/rd_addr -> rd_resp/rd_data, wr_valid/wr_addr/wr_data,
// rq_count (FIFO occupancy), overflow (sticky dropped-read flag).
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int RQ_DEPTH    = DMEM_RQ_DEPTH,
    parameter int RD_LAT      = DMEM_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_valid,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_resp,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic [$clog2(RQ_DEPTH):0]   rq_count,
    output logic                        overflow
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  head_idx;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    port_op_e          port_op;

    logic [RD_LAT-1:0] pipe_vld;
    logic [DATA_W-1:0] pipe_dat [RD_LAT];

    // Low byte-offset bits and high alias bits are deliberately dropped.
    logic              unused_addr_bits;

    assign rd_idx           = rd_addr[2 +: IDX_W];
    assign wr_idx           = wr_addr[2 +: IDX_W];
    assign unused_addr_bits = ^{rd_addr, wr_addr};

    always_comb begin
        port_op = PORT_IDLE;
        unique case (1'b1)
            wr_valid:                 port_op = PORT_WRITE;
            !wr_valid && !fifo_empty: port_op = PORT_READ;
            default:                  port_op = PORT_IDLE;
        endcase
    end

    assign pop = (port_op == PORT_READ);

    rd_req_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (RQ_DEPTH)
    ) u_rq (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_valid),
        .pop   (pop),
        .din   (rd_idx),
        .dout  (head_idx),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rq_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (rd_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // No reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (port_op == PORT_WRITE) mem[wr_idx] <= wr_data;
    end

    // Service cycles never carry a write, so stage 0 never sees a
    // read-during-write on the array.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= pop;
            if (pop) pipe_dat[0] <= mem[head_idx];
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign rd_resp = pipe_vld[RD_LAT-1];
    assign rd_data = pipe_dat[RD_LAT-1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios then random traffic, each cycle
// checked against a queue-based reference of the controller's rules.
module tb_dmem_ctrl;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int DEPTH_WORDS = 1024;
    localparam int RQ_DEPTH    = 4;
    localparam int RD_LAT      = 2;
    localparam int CNT_W       = $clog2(RQ_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rd_valid = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_resp;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  rq_count;
    logic              overflow;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .RQ_DEPTH    (RQ_DEPTH),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_valid (rd_valid),
        .rd_addr  (rd_addr),
        .rd_resp  (rd_resp),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rq_count (rq_count),
        .overflow (overflow)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic [31:0] ref_mem [int];
    int          ref_q [$];
    resp_t       ref_pend [$];
    bit          ref_ovf;
    int          cyc;
    int          n_cmp;
    int          n_err;
    int          obs_cyc [$];
    logic [31:0] obs_dat [$];

    function automatic int widx(logic [31:0] a);
        return int'((a >> 2) % DEPTH_WORDS);
    endfunction

    function automatic int ocyc(int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] odat(int i);
        return (i < obs_dat.size()) ? obs_dat[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the reference.
    task automatic tick(bit rv, logic [31:0] ra, bit wv,
                        logic [31:0] wa, logic [31:0] wd);
        bit exp_resp;
        int idx;
        @(negedge clk);
        exp_resp = (ref_pend.size() > 0) && (ref_pend[0].due == cyc);
        check("rd_resp", 32'(rd_resp), 32'(exp_resp));
        if (exp_resp) begin
            check("rd_data", rd_data, ref_pend[0].data);
            void'(ref_pend.pop_front());
        end
        check("rq_count", 32'(rq_count), 32'(ref_q.size()));
        check("overflow", 32'(overflow), 32'(ref_ovf));
        if (rd_resp === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(rd_data);
        end
        rd_valid = rv;
        rd_addr  = ra;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        if (wv) begin
            ref_mem[widx(wa)] = wd;
        end else if (ref_q.size() > 0) begin
            idx = ref_q.pop_front();
            ref_pend.push_back('{cyc + RD_LAT, ref_mem[idx]});
        end
        if (rv) begin
            if (ref_q.size() < RQ_DEPTH) ref_q.push_back(widx(ra));
            else ref_ovf = 1'b1;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        ref_q.delete();
        ref_pend.delete();
        ref_ovf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        cyc++;
    endtask

    initial begin
        int b;
        int t;
        logic [31:0] a;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        ref_ovf = 1'b0;

        @(posedge clk);
        do_reset();

        // Write then read back at minimum latency.
        tick(0, 0, 1, 32'h40, 32'hDEAD_BEEF);
        b = obs_cyc.size();
        t = cyc;
        tick(1, 32'h40, 0, 0, 0);
        idle(5);
        check("t1_count", 32'(obs_cyc.size() - b), 1);
        check("t1_cycle", ocyc(b), t + 3);
        check("t1_data", odat(b), 32'hDEAD_BEEF);

        // Back-to-back reads give back-to-back responses.
        tick(0, 0, 1, 32'h40, 1);
        tick(0, 0, 1, 32'h44, 2);
        tick(0, 0, 1, 32'h48, 3);
        b = obs_cyc.size();
        t = cyc;
        tick(1, 32'h40, 0, 0, 0);
        tick(1, 32'h44, 0, 0, 0);
        tick(1, 32'h48, 0, 0, 0);
        idle(6);
        check("t2_count", 32'(obs_cyc.size() - b), 3);
        for (int k = 0; k < 3; k++) begin
            check("t2_cycle", ocyc(b + k), t + 3 + k);
            check("t2_data", odat(b + k), k + 1);
        end

        // Writes stall a queued read and are visible to it.
        tick(0, 0, 1, 32'h10, 5);
        b = obs_cyc.size();
        t = cyc;
        tick(1, 32'h10, 0, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 0, 1, 32'h10, 7);
        idle(6);
        check("t3_count", 32'(obs_cyc.size() - b), 1);
        check("t3_cycle", ocyc(b), t + 6);
        check("t3_data", odat(b), 7);

        // Overflow while writes hold the port.
        tick(0, 0, 1, 32'h4C, 4);
        tick(0, 0, 1, 32'h50, 5);
        b = obs_cyc.size();
        for (int k = 0; k < 5; k++)
            tick(1, 32'h40 + 32'(4 * k), 1, 32'h200, 32'(k));
        #1;
        check("t4_rq_count", 32'(rq_count), 4);
        check("t4_overflow", 32'(overflow), 1);
        idle(10);
        check("t4_count", 32'(obs_cyc.size() - b), 4);
        for (int k = 0; k < 4; k++)
            check("t4_data", odat(b + k), k + 1);

        // Address aliasing.
        tick(0, 0, 1, 32'h0, 9);
        b = obs_cyc.size();
        tick(1, 32'(DEPTH_WORDS * 4), 0, 0, 0);
        tick(1, 32'h3, 0, 0, 0);
        idle(5);
        check("t5_count", 32'(obs_cyc.size() - b), 2);
        check("t5_data_wrap", odat(b), 9);
        check("t5_data_low", odat(b + 1), 9);

        // Reset with queued and in-flight reads.
        tick(0, 0, 1, 32'h80, 32'h77);
        tick(1, 32'h40, 1, 32'h200, 0);
        tick(1, 32'h44, 1, 32'h200, 0);
        tick(1, 32'h48, 1, 32'h200, 0);
        tick(1, 32'h4C, 0, 0, 0);
        b = obs_cyc.size();
        do_reset();
        check("t6_resp", 32'(rd_resp), 0);
        check("t6_rq_count", 32'(rq_count), 0);
        check("t6_overflow", 32'(overflow), 0);
        idle(5);
        check("t6_no_resp", 32'(obs_cyc.size() - b), 0);
        tick(1, 32'h80, 0, 0, 0);
        idle(4);
        check("t6_count", 32'(obs_cyc.size() - b), 1);
        check("t6_data", odat(b), 32'h77);

        // Random traffic over a small aliased working set.
        for (int k = 0; k < 16; k++) tick(0, 0, 1, 32'(k * 4), $urandom);
        for (int n = 0; n < 400; n++) begin
            bit rv;
            bit wv;
            logic [31:0] ra;
            logic [31:0] wa;
            rv = 1'($urandom % 2);
            wv = ($urandom % 10) < 3;
            a  = $urandom & 32'hFFFF_F003;
            ra = a | (32'($urandom % 16) << 2);
            a  = $urandom & 32'hFFFF_F003;
            wa = a | (32'($urandom % 16) << 2);
            tick(rv, ra, wv, wa, $urandom);
        end
        idle(12);
        check("drain", 32'(ref_pend.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
